// File: rtl/turn_controller.sv
// Turn sequencer for N-player grid games: tracks the active player and a free-cell cursor,
// commits moves to board memory (manual select or random pick on timeout), then resolves win/draw.
`timescale 1ns/1ps
module turn_controller #(
  parameter int CELLS   = 9,
  parameter int PLAYERS = 2,
  parameter int TIMEOUT = 500_000_000,
  parameter int POS_W   = $clog2(CELLS),
  parameter int PLY_W   = $clog2(PLAYERS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             move,
  input  logic             select,
  input  logic [CELLS-1:0] occupied,
  input  logic             win,
  input  logic             full,
  output logic [POS_W-1:0] cursor,
  output logic [PLY_W-1:0] player,
  output logic             w_e,
  output logic [POS_W-1:0] wr_pos,
  output logic [PLY_W-1:0] wr_player,
  output logic             board_clr,
  output logic [PLY_W-1:0] winner,
  output logic [2:0]       state
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W = $clog2(CELLS + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TURN  = 3'd1,
    ST_PICK  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  // First free cell strictly after cur, wrapping; cur itself when no other cell is free.
  function automatic logic [POS_W-1:0] next_free(input logic [POS_W-1:0] cur,
                                                 input logic [CELLS-1:0] occ);
    logic [POS_W-1:0] res;
    logic [POS_W-1:0] pos;
    int               idx;
    res = cur;
    for (int k = CELLS - 1; k >= 1; k--) begin
      idx = int'(cur) + k;
      idx = (idx >= CELLS) ? idx - CELLS : idx;
      pos = POS_W'(idx);
      res = occ[pos] ? res : pos;
    end
    return res;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t           state_r, state_nxt_s;
  logic [TMR_W-1:0] timer_r, timer_nxt_s;
  logic [POS_W-1:0] ptr_r, ptr_nxt_s;
  logic [CNT_W-1:0] pick_cnt_r, pick_cnt_nxt_s;
  logic [15:0]      lfsr_r, lfsr_nxt_s;
  logic [PLY_W-1:0] player_r, player_nxt_s;
  logic [POS_W-1:0] cursor_r, cursor_nxt_s;
  logic             w_e_r, w_e_nxt_s;
  logic [POS_W-1:0] wr_pos_r, wr_pos_nxt_s;
  logic [PLY_W-1:0] wr_player_r, wr_player_nxt_s;
  logic             board_clr_r, board_clr_nxt_s;
  logic [PLY_W-1:0] winner_r, winner_nxt_s;

  logic sel_ok_s, timeout_s, pick_free_s, pick_last_s;

  assign sel_ok_s    = select & ~occupied[cursor_r];
  assign timeout_s   = (timer_r == TMR_W'(TIMEOUT - 1));
  assign pick_free_s = ~occupied[ptr_r];
  assign pick_last_s = (pick_cnt_r == CNT_W'(CELLS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state selection; in TURN a valid select outranks the timeout, which outranks move
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (start) state_nxt_s = ST_TURN;
        else       state_nxt_s = state_r;
      end
      ST_TURN: begin
        if (sel_ok_s)       state_nxt_s = ST_WRITE;
        else if (timeout_s) state_nxt_s = ST_PICK;
        else                state_nxt_s = ST_TURN;
      end
      ST_PICK: begin
        if (pick_free_s)      state_nxt_s = ST_WRITE;
        else if (pick_last_s) state_nxt_s = ST_CHECK;
        else                  state_nxt_s = ST_PICK;
      end
      ST_WRITE: state_nxt_s = ST_CHECK;
      ST_CHECK: begin
        if (win | full) state_nxt_s = ST_OVER;
        else            state_nxt_s = ST_TURN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of datapath and outputs; pulses default low so they last one cycle
  always_comb begin
    timer_nxt_s     = timer_r;
    ptr_nxt_s       = ptr_r;
    pick_cnt_nxt_s  = pick_cnt_r;
    lfsr_nxt_s      = lfsr_step(lfsr_r);
    player_nxt_s    = player_r;
    cursor_nxt_s    = cursor_r;
    w_e_nxt_s       = 1'b0;
    wr_pos_nxt_s    = wr_pos_r;
    wr_player_nxt_s = wr_player_r;
    board_clr_nxt_s = 1'b0;
    winner_nxt_s    = winner_r;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          board_clr_nxt_s = 1'b1;
          player_nxt_s    = PLY_W'(1);
          cursor_nxt_s    = POS_W'(0);
          timer_nxt_s     = TMR_W'(0);
          winner_nxt_s    = PLY_W'(0);
        end else begin
          board_clr_nxt_s = 1'b0;
        end
      end
      ST_TURN: begin
        timer_nxt_s = timer_r + TMR_W'(1);
        if (sel_ok_s) begin
          w_e_nxt_s       = 1'b1;
          wr_pos_nxt_s    = cursor_r;
          wr_player_nxt_s = player_r;
        end else if (timeout_s) begin
          ptr_nxt_s      = POS_W'(lfsr_r % 16'(CELLS));
          pick_cnt_nxt_s = CNT_W'(0);
        end else if (move) begin
          cursor_nxt_s = next_free(cursor_r, occupied);
        end else begin
          cursor_nxt_s = cursor_r;
        end
      end
      ST_PICK: begin
        if (pick_free_s) begin
          w_e_nxt_s       = 1'b1;
          wr_pos_nxt_s    = ptr_r;
          wr_player_nxt_s = player_r;
          cursor_nxt_s    = ptr_r;
        end else begin
          ptr_nxt_s      = (ptr_r == POS_W'(CELLS - 1)) ? POS_W'(0) : ptr_r + POS_W'(1);
          pick_cnt_nxt_s = pick_cnt_r + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        // occupied already reflects the WRITE-edge update here
        if (win) begin
          winner_nxt_s = player_r;
        end else if (full) begin
          winner_nxt_s = PLY_W'(0);
        end else begin
          player_nxt_s = (player_r == PLY_W'(PLAYERS)) ? PLY_W'(1) : player_r + PLY_W'(1);
          timer_nxt_s  = TMR_W'(0);
          cursor_nxt_s = next_free(wr_pos_r, occupied);
        end
      end
      default: begin
        w_e_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r     <= TMR_W'(0);
      ptr_r       <= POS_W'(0);
      pick_cnt_r  <= CNT_W'(0);
      lfsr_r      <= 16'hACE1;
      player_r    <= PLY_W'(1);
      cursor_r    <= POS_W'(0);
      w_e_r       <= 1'b0;
      wr_pos_r    <= POS_W'(0);
      wr_player_r <= PLY_W'(0);
      board_clr_r <= 1'b0;
      winner_r    <= PLY_W'(0);
    end else begin
      timer_r     <= timer_nxt_s;
      ptr_r       <= ptr_nxt_s;
      pick_cnt_r  <= pick_cnt_nxt_s;
      lfsr_r      <= lfsr_nxt_s;
      player_r    <= player_nxt_s;
      cursor_r    <= cursor_nxt_s;
      w_e_r       <= w_e_nxt_s;
      wr_pos_r    <= wr_pos_nxt_s;
      wr_player_r <= wr_player_nxt_s;
      board_clr_r <= board_clr_nxt_s;
      winner_r    <= winner_nxt_s;
    end
  end

  assign cursor    = cursor_r;
  assign player    = player_r;
  assign w_e       = w_e_r;
  assign wr_pos    = wr_pos_r;
  assign wr_player = wr_player_r;
  assign board_clr = board_clr_r;
  assign winner    = winner_r;
  assign state     = state_r;

endmodule

// File: tb/tb_turn_controller.sv
// Scoreboard bench for turn_controller: stimulus queues expected writes/turns/game-ends/probes,
// a negedge monitor pops and compares them as the DUT presents each event.
`timescale 1ns/1ps
module tb_turn_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT: 9 cells, 2 players, timeout 20
  logic       start, move, select, win, full;
  logic [8:0] occ_base, mem_occ, occupied;
  logic [3:0] cursor, wr_pos;
  logic [1:0] player, wr_player, winner;
  logic       w_e, board_clr;
  logic [2:0] state;
  assign occupied = occ_base | mem_occ;

  turn_controller #(.CELLS(9), .PLAYERS(2), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .start(start), .move(move), .select(select),
    .occupied(occupied), .win(win), .full(full), .cursor(cursor), .player(player),
    .w_e(w_e), .wr_pos(wr_pos), .wr_player(wr_player), .board_clr(board_clr),
    .winner(winner), .state(state));

  // second DUT: 3 players for the player wrap-around
  logic       start3, select3, move3, win3, full3;
  logic [8:0] mem3;
  logic [3:0] cursor3, wr_pos3;
  logic [1:0] player3, wr_player3, winner3;
  logic       w_e3, board_clr3;
  logic [2:0] state3;

  turn_controller #(.CELLS(9), .PLAYERS(3), .TIMEOUT(20)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .move(move3), .select(select3),
    .occupied(mem3), .win(win3), .full(full3), .cursor(cursor3), .player(player3),
    .w_e(w_e3), .wr_pos(wr_pos3), .wr_player(wr_player3), .board_clr(board_clr3),
    .winner(winner3), .state(state3));

  // board memory models
  always @(posedge clk or posedge rst) begin
    if (rst)            mem_occ <= 9'h000;
    else if (board_clr) mem_occ <= 9'h000;
    else if (w_e)       mem_occ[wr_pos] <= 1'b1;
  end
  always @(posedge clk or posedge rst) begin
    if (rst)             mem3 <= 9'h000;
    else if (board_clr3) mem3 <= 9'h000;
    else if (w_e3)       mem3[wr_pos3] <= 1'b1;
  end

  typedef struct packed { logic [3:0] pos; logic [1:0] ply; } wr_t;
  typedef struct {
    string nm; bit which; int mode;
    logic [2:0] st; logic [1:0] ply; logic [3:0] cur;
    logic we; logic clr; logic [1:0] win_p; logic [3:0] wpos; logic [1:0] wply;
  } probe_t;

  wr_t        wr_q[$];
  wr_t        turn_q[$];
  logic [1:0] over_q[$];
  int         clr_q[$];
  probe_t     probe_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         end_req = 1'b0;
  logic [2:0] prev_state = 3'd0;
  probe_t     mp;
  wr_t        me;
  logic [1:0] mw;
  int         mc;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_probe(input string nm, input bit which, input int mode,
                            input logic [2:0] st, input logic [1:0] ply, input logic [3:0] cur,
                            input logic we, input logic clr, input logic [1:0] win_p,
                            input logic [3:0] wpos, input logic [1:0] wply);
    probe_t p;
    p.nm = nm; p.which = which; p.mode = mode; p.st = st; p.ply = ply; p.cur = cur;
    p.we = we; p.clr = clr; p.win_p = win_p; p.wpos = wpos; p.wply = wply;
    probe_q.push_back(p);
  endtask

  task automatic pr(input string nm, input logic [2:0] st, input logic [1:0] ply,
                    input logic [3:0] cur);
    push_probe(nm, 1'b0, 1, st, ply, cur, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0);
  endtask

  task automatic pr_reset(input string nm);
    push_probe(nm, 1'b0, 2, 3'd0, 2'd1, 4'd0, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0);
  endtask

  task automatic wait_state(input string nm, input logic [2:0] tgt, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state == tgt) break;
      tick();
    end
    push_probe(nm, 1'b0, 0, tgt, 2'd0, 4'd0, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0);
  endtask

  // monitor: compares probes and scoreboard events at every negedge
  always @(negedge clk) begin
    while (probe_q.size() > 0) begin
      mp = probe_q.pop_front();
      if (!mp.which) begin
        cmp({mp.nm, "_state"}, 32'(state), 32'(mp.st));
        if (mp.mode >= 1) begin
          cmp({mp.nm, "_player"}, 32'(player), 32'(mp.ply));
          cmp({mp.nm, "_cursor"}, 32'(cursor), 32'(mp.cur));
        end
        if (mp.mode >= 2) begin
          cmp({mp.nm, "_w_e"}, 32'(w_e), 32'(mp.we));
          cmp({mp.nm, "_board_clr"}, 32'(board_clr), 32'(mp.clr));
          cmp({mp.nm, "_winner"}, 32'(winner), 32'(mp.win_p));
          cmp({mp.nm, "_wr_pos"}, 32'(wr_pos), 32'(mp.wpos));
          cmp({mp.nm, "_wr_player"}, 32'(wr_player), 32'(mp.wply));
        end
      end else begin
        cmp({mp.nm, "_state3"}, 32'(state3), 32'(mp.st));
        cmp({mp.nm, "_player3"}, 32'(player3), 32'(mp.ply));
        if (mp.mode >= 2) begin
          cmp({mp.nm, "_w_e3"}, 32'(w_e3), 32'(mp.we));
          cmp({mp.nm, "_wr_player3"}, 32'(wr_player3), 32'(mp.wply));
        end
      end
    end
    if (!rst) begin
      if (w_e) begin
        if (wr_q.size() == 0) cmp("write_unexpected", 32'(w_e), 32'd0);
        else begin
          me = wr_q.pop_front();
          cmp("write_pos", 32'(wr_pos), 32'(me.pos));
          cmp("write_player", 32'(wr_player), 32'(me.ply));
          cmp("write_no_clr", 32'(board_clr), 32'd0);
        end
      end
      if (board_clr) begin
        if (clr_q.size() == 0) cmp("clr_unexpected", 32'(board_clr), 32'd0);
        else begin
          mc = clr_q.pop_front();
          cmp("clr_state", 32'(state), 32'd1);
          cmp("clr_player", 32'(player), 32'd1);
          cmp("clr_cursor", 32'(cursor), 32'd0);
          cmp("clr_winner", 32'(winner), 32'd0);
        end
      end
      if (prev_state == 3'd4 && state == 3'd1) begin
        if (turn_q.size() == 0) cmp("turn_unexpected", 32'(state), 32'd4);
        else begin
          me = turn_q.pop_front();
          cmp("turn_player", 32'(player), 32'(me.ply));
          cmp("turn_cursor", 32'(cursor), 32'(me.pos));
        end
      end
      if (state == 3'd5 && prev_state != 3'd5) begin
        if (over_q.size() == 0) cmp("over_unexpected", 32'(state), 32'd4);
        else begin
          mw = over_q.pop_front();
          cmp("over_winner", 32'(winner), 32'(mw));
          cmp("over_no_write", 32'(w_e), 32'd0);
        end
      end
    end
    prev_state = state;
    if (end_req) begin
      cmp("write_queue_drained", 32'(wr_q.size()), 32'd0);
      cmp("turn_queue_drained", 32'(turn_q.size()), 32'd0);
      cmp("over_queue_drained", 32'(over_q.size()), 32'd0);
      cmp("clr_queue_drained", 32'(clr_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 0; move = 0; select = 0; occ_base = 9'h000; win = 0; full = 0;
    start3 = 0; select3 = 0; move3 = 0; win3 = 0; full3 = 0;
    repeat (2) @(posedge clk);
    #1;
    pr_reset("reset");
    tick();
    rst = 1'b0;

    // game start
    clr_q.push_back(1);
    start = 1; tick(); start = 0;
    pr("start", 3'd1, 2'd1, 4'd0);

    // cursor movement
    occ_base = 9'h006; move = 1; tick(); move = 0;
    pr("move_skip", 3'd1, 2'd1, 4'd3);
    occ_base = 9'h000;
    repeat (5) begin move = 1; tick(); move = 0; end
    pr("move_to8", 3'd1, 2'd1, 4'd8);
    move = 1; tick(); move = 0;
    pr("move_wrap", 3'd1, 2'd1, 4'd0);
    occ_base = 9'h1FE; move = 1; tick(); move = 0;
    pr("move_none", 3'd1, 2'd1, 4'd0);

    // manual select of cell 3
    occ_base = 9'h000;
    repeat (3) begin move = 1; tick(); move = 0; end
    pr("cur3", 3'd1, 2'd1, 4'd3);
    wr_q.push_back('{pos: 4'd3, ply: 2'd1});
    turn_q.push_back('{pos: 4'd4, ply: 2'd2});
    select = 1; tick(); select = 0;
    pr("sel_write", 3'd3, 2'd1, 4'd3);
    wait_state("back_turn1", 3'd1, 4);

    // timeout auto-pick with one free cell
    occ_base = 9'h1FE;
    repeat (19) tick();
    pr("pre_timeout", 3'd1, 2'd2, 4'd4);
    wr_q.push_back('{pos: 4'd0, ply: 2'd2});
    turn_q.push_back('{pos: 4'd0, ply: 2'd1});
    tick();
    pr("timeout_pick", 3'd2, 2'd2, 4'd4);
    wait_state("pick_write", 3'd3, 9);
    pr("pick_cursor", 3'd3, 2'd2, 4'd0);
    wait_state("back_turn2", 3'd1, 4);

    // select in the timeout cycle wins over the auto-pick
    occ_base = 9'h000;
    repeat (3) begin move = 1; tick(); move = 0; end
    pr("cur4", 3'd1, 2'd1, 4'd4);
    repeat (16) tick();
    wr_q.push_back('{pos: 4'd4, ply: 2'd1});
    turn_q.push_back('{pos: 4'd5, ply: 2'd2});
    select = 1; tick(); select = 0;
    pr("sel_beats_timeout", 3'd3, 2'd1, 4'd4);
    wait_state("back_turn3", 3'd1, 4);

    // win has priority over full
    win = 1; full = 1;
    wr_q.push_back('{pos: 4'd5, ply: 2'd2});
    over_q.push_back(2'd2);
    select = 1; tick(); select = 0;
    wait_state("over_win", 3'd5, 4);
    move = 1; select = 1; tick(); move = 0; select = 0;
    pr("over_hold", 3'd5, 2'd2, 4'd5);
    win = 0; full = 0;
    clr_q.push_back(1);
    start = 1; tick(); start = 0;
    pr("restart", 3'd1, 2'd1, 4'd0);
    tick();

    // draw
    full = 1;
    wr_q.push_back('{pos: 4'd0, ply: 2'd1});
    over_q.push_back(2'd0);
    select = 1; tick(); select = 0;
    wait_state("over_draw", 3'd5, 4);
    full = 0;

    // asynchronous reset in the middle of PICK
    clr_q.push_back(1);
    start = 1; tick(); start = 0;
    occ_base = 9'h1FF;
    tick();
    wait_state("pick_enter", 3'd2, 25);
    tick();
    rst = 1;
    pr_reset("rst_in_pick");
    #6; rst = 0;
    occ_base = 9'h000;
    tick();
    pr("post_rst", 3'd0, 2'd1, 4'd0);

    // asynchronous reset in the middle of WRITE
    clr_q.push_back(1);
    start = 1; tick(); start = 0;
    tick();
    repeat (2) begin move = 1; tick(); move = 0; end
    pr("cur2", 3'd1, 2'd1, 4'd2);
    select = 1; tick(); select = 0;
    rst = 1;
    pr_reset("rst_in_write");
    #6; rst = 0;
    tick();

    // three-player rotation on the second instance
    start3 = 1; tick(); start3 = 0;
    for (int p = 1; p <= 3; p++) begin
      select3 = 1; tick(); select3 = 0;
      push_probe("p3_write", 1'b1, 2, 3'd3, 2'(p), 4'd0, 1'b1, 1'b0, 2'd0, 4'd0, 2'(p));
      for (int i = 0; i < 4; i++) begin
        if (state3 == 3'd1) break;
        tick();
      end
      push_probe("p3_next", 1'b1, 1, 3'd1, 2'((p % 3) + 1), 4'd0,
                 1'b0, 1'b0, 2'd0, 4'd0, 2'd0);
    end

    repeat (2) tick();
    end_req = 1'b1;
  end

endmodule
